// File: rtl/seg7_pkg.sv
// seg7_pkg: scan states, blank pattern and hex-to-segment decode for the 7-seg scanner
package seg7_pkg;
  typedef enum logic [1:0] {RST_IDLE, BLANK, SHOW} scan_state_t;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    case (h)
      4'h0: hex2seg = 7'b0000001;
      4'h1: hex2seg = 7'b1001111;
      4'h2: hex2seg = 7'b0010010;
      4'h3: hex2seg = 7'b0000110;
      4'h4: hex2seg = 7'b1001100;
      4'h5: hex2seg = 7'b0100100;
      4'h6: hex2seg = 7'b0100000;
      4'h7: hex2seg = 7'b0001111;
      4'h8: hex2seg = 7'b0000000;
      4'h9: hex2seg = 7'b0000100;
      4'hA: hex2seg = 7'b0001000;
      4'hB: hex2seg = 7'b1100000;
      4'hC: hex2seg = 7'b0110001;
      4'hD: hex2seg = 7'b1000010;
      4'hE: hex2seg = 7'b0110000;
      default: hex2seg = 7'b0111000;
    endcase
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchronizer plus DEB_LEN-sample shift register; one pulse per qualified press
module btn_debounce #(
  parameter int DEB_LEN = 4
) (
  input  logic CLK100,
  input  logic resetn,
  input  logic btn_i,
  output logic press_o
);
  logic s1_q, s2_q, full_q;
  logic [DEB_LEN-1:0] sh_q, sh_d;
  always_comb sh_d = DEB_LEN'({sh_q, s2_q});
  assign press_o = &sh_q & ~full_q;
  always_ff @(posedge CLK100) begin
    if (!resetn) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      sh_q <= '0;
      full_q <= 1'b0;
    end else begin
      s1_q <= btn_i;
      s2_q <= s1_q;
      sh_q <= sh_d;
      full_q <= &sh_q;
    end
  end
endmodule

// File: rtl/seg7_scan_arbiter.sv
// seg7_scan_arbiter: 8-digit scan with anode blanking, sharing the display between CPU word and switches
module seg7_scan_arbiter import seg7_pkg::*; #(
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 16,
  parameter int DEB_LEN   = 4
) (
  input  logic        CLK100,
  input  logic        resetn,
  input  logic [31:0] cpu_data_i,
  input  logic        cpu_valid_i,
  input  logic [15:0] sw_data_i,
  input  logic        btn_sel_i,
  input  logic [7:0]  digit_en_i,
  output logic [6:0]  seg_o,
  output logic [7:0]  an_o,
  output logic        src_o,
  output logic        frame_o
);
  localparam int CW = $clog2(SCAN_DIV);
  scan_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] d_q, d_d;
  logic [31:0] snap_q, snap_d, fb_q, fb_d;
  logic [7:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic pend_q, pend_d, src_q, src_d, frame_q, frame_d;
  logic press, last, wrap, boundary;
  btn_debounce #(.DEB_LEN(DEB_LEN)) u_deb (
    .CLK100 (CLK100),
    .resetn (resetn),
    .btn_i  (btn_sel_i),
    .press_o(press)
  );
  // a frame reload sees this cycle's valid CPU word, so the first frame after reset is not stale
  always_comb begin
    snap_d = cpu_valid_i ? cpu_data_i : snap_q;
    last = state_q == SHOW && cnt_q == CW'(SCAN_DIV - 1);
    wrap = last && d_q == 3'd7;
    boundary = state_q == RST_IDLE || wrap;
    src_d = src_q ^ (wrap & pend_q);
    pend_d = (wrap ? 1'b0 : pend_q) ^ press;
    fb_d = boundary ? (src_d ? {16'h0, sw_data_i} : snap_d) : fb_q;
    state_d = state_q == RST_IDLE ? BLANK :
              state_q == BLANK ? (cnt_q == CW'(BLANK_CYC - 1) ? SHOW : BLANK) :
              (last ? BLANK : SHOW);
    cnt_d = (state_q == RST_IDLE || last) ? '0 : cnt_q + 1'b1;
    d_d = state_q == RST_IDLE ? 3'd0 : d_q + {2'b00, last};
    an_d = (state_d == SHOW && digit_en_i[d_d]) ? ~(8'd1 << d_d) : 8'hFF;
    seg_d = (state_d == SHOW && !digit_en_i[d_d]) ? SEG_BLANK : hex2seg(fb_d[{d_d, 2'b00} +: 4]);
    frame_d = wrap;
  end
  always_ff @(posedge CLK100) begin
    if (!resetn) begin
      state_q <= RST_IDLE;
      cnt_q <= '0;
      d_q <= 3'd0;
      snap_q <= 32'h0;
      fb_q <= 32'h0;
      pend_q <= 1'b0;
      src_q <= 1'b0;
      frame_q <= 1'b0;
      an_q <= 8'hFF;
      seg_q <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      d_q <= d_d;
      snap_q <= snap_d;
      fb_q <= fb_d;
      pend_q <= pend_d;
      src_q <= src_d;
      frame_q <= frame_d;
      an_q <= an_d;
      seg_q <= seg_d;
    end
  end
  assign seg_o = seg_q;
  assign an_o = an_q;
  assign src_o = src_q;
  assign frame_o = frame_q;
endmodule

// File: tb/tb_seg7_scan_arbiter.sv
// tb_seg7_scan_arbiter: positional scan model checked every cycle, plus directed literal checks
module tb_seg7_scan_arbiter;
  localparam int SD = 10, BC = 2, DL = 4;
  logic clk = 1'b0, resetn = 1'b0;
  logic [31:0] cpu_data_i = 32'h0;
  logic cpu_valid_i = 1'b0;
  logic [15:0] sw_data_i = 16'h0;
  logic btn_sel_i = 1'b0;
  logic [7:0] digit_en_i = 8'hFF;
  logic [6:0] seg_o;
  logic [7:0] an_o;
  logic src_o, frame_o;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  seg7_scan_arbiter #(.SCAN_DIV(SD), .BLANK_CYC(BC), .DEB_LEN(DL)) dut (
    .CLK100(clk), .resetn(resetn), .cpu_data_i(cpu_data_i), .cpu_valid_i(cpu_valid_i),
    .sw_data_i(sw_data_i), .btn_sel_i(btn_sel_i), .digit_en_i(digit_en_i),
    .seg_o(seg_o), .an_o(an_o), .src_o(src_o), .frame_o(frame_o)
  );
  logic [6:0] hex_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endfunction
  // model: position p counts cycles since the RST_IDLE edge; slot, offset and frame follow by division
  int k = 0, run = 0, p, slot, off;
  logic m_src = 1'b0, m_pend = 1'b0, m_fr = 1'b0;
  logic [31:0] m_snap = 32'h0, m_word = 32'h0;
  logic [7:0] e_an;
  logic [6:0] e_seg;
  always @(posedge clk) begin
    if (!resetn) begin
      k = 0; run = 0; m_src = 1'b0; m_pend = 1'b0; m_fr = 1'b0;
      m_snap = 32'h0; m_word = 32'h0; e_an = 8'hFF; e_seg = 7'h7F;
    end else begin
      k++;
      p = k - 1;
      m_fr = 1'b0;
      if (cpu_valid_i) m_snap = cpu_data_i;
      if (p > 0 && p % (8 * SD) == 0) begin
        m_fr = 1'b1;
        m_src ^= m_pend;
        m_pend = 1'b0;
      end
      if (p % (8 * SD) == 0) m_word = m_src ? {16'h0, sw_data_i} : m_snap;
      run = btn_sel_i ? run + 1 : 0;
      if (run == DL) m_pend ^= 1'b1;
      slot = (p / SD) % 8;
      off = p % SD;
      e_seg = hex_tab[m_word[4*slot +: 4]];
      e_an = 8'hFF;
      if (off >= BC) begin
        if (digit_en_i[slot]) e_an = ~(8'd1 << slot);
        else e_seg = 7'h7F;
      end
    end
    #1;
    chk("model_an", an_o, e_an);
    chk("model_seg", seg_o, e_seg);
    chk("model_src", src_o, m_src);
    chk("model_frame", frame_o, m_fr);
  end
  task automatic wait_frame(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_o && n < 400);
    chk("wait_frame", frame_o, 1);
  endtask
  task automatic wait_an(input logic [7:0] v);
    int n = 0;
    do begin @(negedge clk); n++; end while (an_o !== v && n < 400);
    chk("wait_an", an_o, v);
  endtask
  task automatic hold_btn(input logic v, input int cyc);
    btn_sel_i = v;
    repeat (cyc) @(negedge clk);
  endtask
  initial begin
    int n;
    logic bad;
    cpu_valid_i = 1'b1;
    cpu_data_i = 32'h1234ABCD;
    repeat (3) @(negedge clk);
    chk("reset_an", an_o, 8'hFF);
    chk("reset_seg", seg_o, 7'h7F);
    chk("reset_src", src_o, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    chk("first_blank_an", an_o, 8'hFF);
    @(negedge clk);
    chk("first_show_an", an_o, 8'hFE);
    chk("digit0_d", seg_o, 7'b1000010);
    repeat (7) @(negedge clk);
    chk("slot0_last_an", an_o, 8'hFE);
    @(negedge clk);
    chk("slot1_blank_an", an_o, 8'hFF);
    repeat (2) @(negedge clk);
    chk("slot1_an", an_o, 8'hFD);
    chk("digit1_C", seg_o, 7'b0110001);
    wait_an(8'hFB);
    chk("digit2_b", seg_o, 7'b1100000);
    wait_frame(n);
    wait_frame(n);
    chk("frame_period", n, 8 * SD);
    digit_en_i = 8'h0F;
    n = 0;
    bad = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (an_o[7:4] !== 4'hF) bad = 1'b1;
    end while (!frame_o && n < 400);
    chk("mask_an_high", bad, 0);
    chk("mask_period", n, 8 * SD);
    digit_en_i = 8'hFF;
    repeat (20) @(negedge clk);
    cpu_data_i = 32'hDEADBEEF;
    wait_an(8'h7F);
    chk("cpu_old_digit7", seg_o, 7'b1001111);
    wait_frame(n);
    wait_an(8'hFE);
    chk("cpu_new_digit0", seg_o, 7'b0111000);
    repeat (20) @(negedge clk);
    sw_data_i = 16'h00A5;
    hold_btn(1'b1, 10);
    hold_btn(1'b0, 10);
    chk("src_before_frame", src_o, 0);
    wait_frame(n);
    chk("src_switched", src_o, 1);
    wait_an(8'hFE);
    chk("sw_digit0_5", seg_o, 7'b0100100);
    wait_an(8'hFD);
    chk("sw_digit1_A", seg_o, 7'b0001000);
    wait_an(8'hFB);
    chk("sw_digit2_0", seg_o, 7'b0000001);
    hold_btn(1'b1, 3);
    hold_btn(1'b0, 5);
    wait_frame(n);
    chk("glitch_no_switch", src_o, 1);
    repeat (10) @(negedge clk);
    hold_btn(1'b1, 6);
    hold_btn(1'b0, 6);
    hold_btn(1'b1, 6);
    hold_btn(1'b0, 6);
    wait_frame(n);
    chk("double_press_cancel", src_o, 1);
    wait_an(8'hFB);
    resetn = 1'b0;
    @(negedge clk);
    chk("midreset_an", an_o, 8'hFF);
    chk("midreset_seg", seg_o, 7'h7F);
    chk("midreset_src", src_o, 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
